// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the progressive-sequence memory game.
// Sequences the datapath (address counter, round-limit counter, play register),
// evaluates its status flags and owns the per-play timeout counter.
//
// state           | code | meaning
// ----------------+------+-----------------------------------------------
// inicial         | 0x0  | idle, waiting for iniciar
// preparacao      | 0x1  | clear address, limit and play register
// inicio_rodada   | 0x2  | clear address counter for a new round
// espera_jogada   | 0x3  | waiting for a key press, timeout running
// registra        | 0x4  | load the pressed key into the play register
// comparacao      | 0x5  | evaluate igual / fimE / fimL
// proximo         | 0x6  | advance to the next address in this round
// proxima_rodada  | 0x7  | extend the round limit by one
// fim_acerto      | 0xA  | game won
// fim_timeout     | 0xD  | game lost, no key pressed in time
// fim_erro        | 0xE  | game lost, wrong key

module unidade_controle_rodadas #(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int TW             = $clog2(TIMEOUT_CICLOS)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        S_INICIAL        = 4'h0,
        S_PREPARACAO     = 4'h1,
        S_INICIO_RODADA  = 4'h2,
        S_ESPERA_JOGADA  = 4'h3,
        S_REGISTRA       = 4'h4,
        S_COMPARACAO     = 4'h5,
        S_PROXIMO        = 4'h6,
        S_PROXIMA_RODADA = 4'h7,
        S_FIM_ACERTO     = 4'hA,
        S_FIM_TIMEOUT    = 4'hD,
        S_FIM_ERRO       = 4'hE
    } estado_t;

    localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);

    estado_t       r_estado;
    estado_t       w_prox;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_prox;
    // bit order: zeraE contaE zeraL contaL zeraR registraR pronto acertou errou db_timeout
    logic [9:0]    r_saidas;

    // Output decode of a state; outputs are registered from the next state so
    // they always match the state register without a combinational path.
    function automatic logic [9:0] decodifica(input estado_t e);
        logic [9:0] s;
        s = '0;
        case (e)
            S_PREPARACAO:     s = 10'b1010100000;
            S_INICIO_RODADA:  s = 10'b1000000000;
            S_REGISTRA:       s = 10'b0000010000;
            S_PROXIMO:        s = 10'b0100000000;
            S_PROXIMA_RODADA: s = 10'b0001000000;
            S_FIM_ACERTO:     s = 10'b0000001100;
            S_FIM_ERRO:       s = 10'b0000001010;
            S_FIM_TIMEOUT:    s = 10'b0000001011;
            default:          s = '0;
        endcase
        return s;
    endfunction

    // Next-state and timer logic; the timer only counts while staying in espera_jogada.
    always_comb begin
        w_prox       = r_estado;
        w_timer_prox = '0;
        case (r_estado)
            S_INICIAL:        if (iniciar) w_prox = S_PREPARACAO;
            S_PREPARACAO:     w_prox = S_INICIO_RODADA;
            S_INICIO_RODADA:  w_prox = S_ESPERA_JOGADA;
            S_ESPERA_JOGADA: begin
                // a key press in the last cycle of the window still counts
                if (jogada)
                    w_prox = S_REGISTRA;
                else if (r_timer == TIMER_FIM)
                    w_prox = S_FIM_TIMEOUT;
                else
                    w_timer_prox = r_timer + TW'(1);
            end
            S_REGISTRA:       w_prox = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!igual)
                    w_prox = S_FIM_ERRO;
                else if (fimE && fimL)
                    w_prox = S_FIM_ACERTO;
                else if (fimE)
                    w_prox = S_PROXIMA_RODADA;
                else
                    w_prox = S_PROXIMO;
            end
            S_PROXIMO:        w_prox = S_ESPERA_JOGADA;
            S_PROXIMA_RODADA: w_prox = S_INICIO_RODADA;
            S_FIM_ACERTO,
            S_FIM_ERRO,
            S_FIM_TIMEOUT:    if (iniciar) w_prox = S_PREPARACAO;
            default:          w_prox = S_INICIAL;
        endcase
    end

    // State, timer and registered outputs; reset aborts the game at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= S_INICIAL;
            r_timer  <= '0;
            r_saidas <= '0;
        end else begin
            r_estado <= w_prox;
            r_timer  <= w_timer_prox;
            r_saidas <= decodifica(w_prox);
        end
    end

    assign zeraE      = r_saidas[9];
    assign contaE     = r_saidas[8];
    assign zeraL      = r_saidas[7];
    assign contaL     = r_saidas[6];
    assign zeraR      = r_saidas[5];
    assign registraR  = r_saidas[4];
    assign pronto     = r_saidas[3];
    assign acertou    = r_saidas[2];
    assign errou      = r_saidas[1];
    assign db_timeout = r_saidas[0];
    assign db_estado  = r_estado;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for unidade_controle_rodadas with a short timeout window.
module tb_unidade_controle_rodadas;

    localparam int TO = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimE = 1'b0, fimL = 1'b0;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    unidade_controle_rodadas #(.TIMEOUT_CICLOS(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .acertou(acertou), .errou(errou), .db_timeout(db_timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int contal_pulsos = 0;
    logic [13:0] sb_q[$];

    typedef struct {
        logic       ini, jog, ig, fe, fl;
        logic [3:0] exp_e;
    } vec_t;
    vec_t tab[$];

    // expected outputs of each state code, straight from the state table
    function automatic logic [9:0] exp_outs(input logic [3:0] e);
        case (e)
            4'h1:    return 10'b1010100000;
            4'h2:    return 10'b1000000000;
            4'h4:    return 10'b0000010000;
            4'h6:    return 10'b0100000000;
            4'h7:    return 10'b0001000000;
            4'hA:    return 10'b0000001100;
            4'hE:    return 10'b0000001010;
            4'hD:    return 10'b0000001011;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [13:0] obs();
        return {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR,
                pronto, acertou, errou, db_timeout};
    endfunction

    task automatic chk(input string nome, input logic [13:0] act, input logic [13:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (estado,saidas)", nome, act, req);
        end
    endtask

    task automatic step(input logic ini, input logic jog, input logic ig,
                        input logic fe, input logic fl,
                        input logic [3:0] exp_e, input string nome);
        logic [13:0] esperado;
        iniciar = ini; jogada = jog; igual = ig; fimE = fe; fimL = fl;
        sb_q.push_back({exp_e, exp_outs(exp_e)});
        @(posedge clock);
        #1;
        if (contaL) contal_pulsos++;
        esperado = sb_q.pop_front();
        chk(nome, obs(), esperado);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // start sequence, one round won, mismatch on round 2 second play
        tab.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3});
        tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5});
        tab.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h7});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3});
        tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5});
        tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3});
        tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hE});
        tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE});
        tab.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hE});

        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("reset_hold", obs(), 14'h0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 4'h0, "pos_reset");

        for (int i = 0; i < tab.size(); i++)
            step(tab[i].ini, tab[i].jog, tab[i].ig, tab[i].fe, tab[i].fl,
                 tab[i].exp_e, $sformatf("tab_%0d", i));

        // full 4-word game from fim_erro; flags come from the bench's datapath model
        step(1, 0, 0, 0, 0, 4'h1, "restart_E");
        step(0, 0, 0, 0, 0, 4'h2, "jogo_inicio");
        step(0, 0, 0, 0, 0, 4'h3, "jogo_espera");
        contal_pulsos = 0;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p <= r; p++) begin
                logic       fe, fl;
                logic [3:0] v;
                fe = (p == r);
                fl = (r == 3);
                v  = (fe && fl) ? 4'hA : (fe ? 4'h7 : 4'h6);
                step(0, 1, 0, 0, 0, 4'h4, "jogo_registra");
                step(0, 0, 0, 0, 0, 4'h5, "jogo_compara");
                step(0, 0, 1, fe, fl, v, $sformatf("jogo_veredito_r%0d_p%0d", r, p));
                if (v == 4'h6) begin
                    step(0, 0, 0, 0, 0, 4'h3, "jogo_proximo");
                end else if (v == 4'h7) begin
                    step(0, 0, 0, 0, 0, 4'h2, "jogo_rodada");
                    step(0, 0, 0, 0, 0, 4'h3, "jogo_espera");
                end
            end
        end
        chk("contaL_pulsos", 14'(contal_pulsos), 14'd3);
        for (int k = 0; k < 3; k++)
            step(0, 1, 1, 1, 1, 4'hA, "acerto_fica");

        // timeout window of exactly TO cycles in espera_jogada
        step(1, 0, 0, 0, 0, 4'h1, "restart_A");
        step(0, 0, 0, 0, 0, 4'h2, "to_inicio");
        step(0, 0, 0, 0, 0, 4'h3, "to_espera_1");
        for (int k = 2; k <= TO; k++)
            step(0, 0, 0, 0, 0, 4'h3, $sformatf("to_espera_%0d", k));
        step(0, 0, 0, 0, 0, 4'hD, "timeout");
        step(0, 1, 1, 0, 0, 4'hD, "timeout_fica");

        // restart from fim_timeout; key in the last cycle of the window wins
        step(1, 0, 0, 0, 0, 4'h1, "restart_D");
        step(0, 0, 0, 0, 0, 4'h2, "lim_inicio");
        step(0, 0, 0, 0, 0, 4'h3, "lim_espera_1");
        for (int k = 2; k <= TO; k++)
            step(0, 0, 0, 0, 0, 4'h3, $sformatf("lim_espera_%0d", k));
        step(0, 1, 0, 0, 0, 4'h4, "jogada_limite");

        // asynchronous reset between edges while in registra
        #2;
        reset = 1'b0;
        #1;
        chk("reset_async", obs(), 14'h0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 4'h0, "pos_reset_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
- Moore control unit for the progressive-sequence memory game (rounds of growing length, played on `chaves`, compared against the stored sequence).
- Sequences the game datapath: address counter, round-limit counter and play register.
- Evaluates the datapath status flags and owns the per-play timeout counter.
- Sits beside the datapath inside the top-level game circuit. Drives its `pronto`, `acertou` and `errou` outputs plus the `db_estado` debug display.

Parameters:
- TIMEOUT_CICLOS, 3000, clock cycles allowed per play in espera_jogada (3 s at 1 kHz). Legal range ≥ 2.
- TW, $clog2(TIMEOUT_CICLOS), width of the internal timeout counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- iniciar  in  1  start/restart request, level-sampled.
- jogada  in  1  one-cycle pulse from the datapath edge detector: a key was pressed.
- igual  in  1  play register equals memory word at current address.
- fimE  in  1  address counter equals round limit.
- fimL  in  1  round limit equals last address (final round).
- zeraE  out  1  clear address counter.
- contaE  out  1  increment address counter.
- zeraL  out  1  clear limit counter.
- contaL  out  1  increment limit counter.
- zeraR  out  1  clear play register.
- registraR  out  1  load play register.
- pronto  out  1  game finished.
- acertou  out  1  game won.
- errou  out  1  game lost (mismatch or timeout).
- db_timeout  out  1  loss was caused by timeout.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0, asynchronous): state ← inicial (0x0), timer ← 0.
  - All outputs are 0 while reset is held and in the first cycle after it.
  - Reset mid-game aborts immediately; no datapath command is issued.
- All outputs are a pure decode of the state (Moore). No input-to-output combinational path.
- States, codes, asserted outputs and transitions:
  - inicial 0x0: no outputs. iniciar=1 → preparacao; else stay.
  - preparacao 0x1: zeraE, zeraL, zeraR. → inicio_rodada.
  - inicio_rodada 0x2: zeraE. → espera_jogada.
  - espera_jogada 0x3: no outputs; timer increments each cycle.
    - jogada=1 → registra. A jogada in the same cycle as timer==TIMEOUT_CICLOS-1 wins over timeout.
    - else timer==TIMEOUT_CICLOS-1 → fim_timeout.
    - else stay.
  - registra 0x4: registraR. → comparacao.
  - comparacao 0x5, evaluated in priority order:
    - igual=0 → fim_erro.
    - fimE=1 and fimL=1 → fim_acerto.
    - fimE=1 → proxima_rodada.
    - else → proximo.
  - proximo 0x6: contaE. → espera_jogada.
  - proxima_rodada 0x7: contaL. → inicio_rodada.
  - fim_acerto 0xA: pronto, acertou. iniciar=1 → preparacao; else stay.
  - fim_erro 0xE: pronto, errou. iniciar=1 → preparacao; else stay.
  - fim_timeout 0xD: pronto, errou, db_timeout. iniciar=1 → preparacao; else stay.
- Timer:
  - TW-bit counter.
  - Forced to 0 in every cycle where the state is not espera_jogada, so each play gets a full window.
  - Never wraps: leaving espera_jogada at TIMEOUT_CICLOS-1 is mandatory.
- Latency:
  - Key pulse to registraR: 1 cycle.
  - Key pulse to verdict state (fim_*, proximo or proxima_rodada): 3 cycles.
  - Timeout: exactly TIMEOUT_CICLOS cycles spent in espera_jogada, then fim_timeout.
- jogada and iniciar are ignored in states where they are not listed.
- Unused codes (0x8, 0x9, 0xB, 0xC, 0xF) → inicial on the next clock.
- Unused codes decode all outputs to 0, and db_estado shows the raw code.

Test Plan:
- Reset and start: reset=0 for 10 cycles → db_estado=0, all outputs 0. Release, iniciar=1 for 1 cycle → db_estado sequence 0,1,2,3 with zeraE/zeraL/zeraR high in state 1 only.
- Correct full game: drive a 4-word sequence with fimE/fimL from a behavioural datapath model, all plays matching (10 plays total) → contaL pulses 3 times. Final state 0xA with pronto=1, acertou=1, errou=0; stays there until iniciar.
- Mismatch: in round 2, second play, igual=0 → 0x5 then 0xE. pronto=1, errou=1, db_timeout=0, no further contaE/contaL.
- Timeout: TIMEOUT_CICLOS=5, no jogada in espera_jogada → exactly 5 cycles in 0x3, then 0xD with errou=1, db_timeout=1. Variant: jogada in the 5th cycle → registra (0x4), no timeout.
- Restart from end states: iniciar=1 in 0xA, 0xE and 0xD → each goes to 0x1 next cycle, and the timer restarts from 0 on the next espera_jogada.
- Async reset mid-game: drop reset between clock edges while in 0x4 → db_estado=0 and registraR=0 immediately, before the next clock edge.
